// File: rtl/mac_result_drain_pkg.sv
// Shared definitions for the matrix-multiply result drain: geometry constants,
// the drain FSM state type and the optional 16-bit output saturation helper.
package mac_pkg;

  localparam int MAC_DIM      = 4;
  localparam int MAC_ELEM_W   = 32;
  localparam int MAC_NUM_ELEM = MAC_DIM * MAC_DIM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } drain_state_t;

  // Clamp a signed element into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [MAC_ELEM_W-1:0] v);
    logic signed [15:0] r;
    if (v > $signed(MAC_ELEM_W'(32767))) begin
      r = 16'sh7FFF;
    end else if (v < -$signed(MAC_ELEM_W'(32768))) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_result_drain_rise_detect.sv
// Single-bit rising-edge detector: registers the input and flags in & ~in_q.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  // Previous-cycle copy of the input, cleared by reset so a level held high
  // across reset release is seen as a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/mac_result_drain.sv
// Captures the 4x4 result matrix on the rising edge of done_matrix_mult and
// streams it out row-major over valid/ready. Define MAC_DRAIN_SAT16_EN to
// saturate each output word to signed 16-bit range.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int ELEM_W   = MAC_ELEM_W,
  parameter int NUM_ELEM = MAC_NUM_ELEM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done_matrix_mult,
  input  logic [ELEM_W*NUM_ELEM-1:0] y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic                       out_last,
  output logic [3:0]                 out_index,
  output logic                       drain_done,
  output logic                       overrun
);

  localparam int VEC_W = ELEM_W * NUM_ELEM;
  localparam int IDX_W = 4;
  localparam int SEL_W = $clog2(VEC_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  logic               capture_s;
  logic               load_s;
  drain_state_t       state_r;
  drain_state_t       state_nxt_s;
  logic [IDX_W-1:0]   index_r;
  logic [IDX_W-1:0]   index_nxt_s;
  logic [VEC_W-1:0]   hold_r;
  logic               overrun_r;
  logic [SEL_W-1:0]   sel_lsb_s;
  logic [ELEM_W-1:0]  elem_s;

  rise_detect u_capture_rise (
    .clk   (clk),
    .reset (reset),
    .in    (done_matrix_mult),
    .rise  (capture_s)
  );

  // Drain FSM next-state and index sequencing.
  always_comb begin
    state_nxt_s = state_r;
    index_nxt_s = index_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_nxt_s = STREAM;
          index_nxt_s = '0;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (index_r == LAST_IDX) begin
            state_nxt_s = FINISH;
          end else begin
            index_nxt_s = index_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = STREAM;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        index_nxt_s = '0;
      end
    endcase
  end

  // State, index and holding register; the holding register only loads on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      index_r <= '0;
      hold_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      index_r <= index_nxt_s;
      if (load_s) begin
        hold_r <= y;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // A capture edge outside IDLE is dropped but latched as a sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (capture_s && (state_r != IDLE)) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Element 0 (C[0][0]) sits in the most significant word of the vector.
  always_comb begin
    sel_lsb_s = SEL_W'((NUM_ELEM - 1 - int'(index_r)) * ELEM_W);
    elem_s    = hold_r[sel_lsb_s +: ELEM_W];
  end

`ifdef MAC_DRAIN_SAT16_EN
  logic signed [15:0] sat_s;

  // Saturate the selected element and sign-extend back to the bus width.
  always_comb begin
    sat_s    = sat16(elem_s);
    out_data = {{(ELEM_W-16){sat_s[15]}}, sat_s};
  end
`else
  assign out_data = elem_s;
`endif

  assign out_valid  = (state_r == STREAM);
  assign out_last   = (state_r == STREAM) && (index_r == LAST_IDX);
  assign out_index  = index_r;
  assign drain_done = (state_r == FINISH);
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: stimulus pushes expected beats,
// a negedge monitor pops and compares on every accepted handshake.
module tb_mac_result_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         done_matrix_mult;
  logic [511:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [3:0]   out_index;
  logic         drain_done;
  logic         overrun;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_hs_cyc = -10;

  mac_result_drain dut (
    .clk              (clk),
    .reset            (reset),
    .done_matrix_mult (done_matrix_mult),
    .y                (y),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .out_index        (out_index),
    .drain_done       (drain_done),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input int i, input logic [31:0] v);
    y[511-32*i -: 32] = v;
  endtask

  task automatic push(input int i, input logic [31:0] v);
    exp_q.push_back(beat_t'{data: v, idx: 4'(i), last: (i == 15)});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_index"}, 64'(out_index), 64'd0);
    check({tag, "_done"}, 64'(drain_done), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && !drain_done; k++) tick;
    check({name, "_drain_done"}, 64'(drain_done), 64'd1);
    tick;
    check({name, "_all_consumed"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_index(input logic [3:0] idx, input string name);
    for (int k = 0; k < 100 && !(out_valid && out_index == idx); k++) tick;
    check({name, "_reach_index"}, 64'(out_index), 64'(idx));
  endtask

  // Monitor: pops on handshake, checks hold stability and drain_done timing.
  initial begin
    logic  prev_stall;
    beat_t prev_beat;
    beat_t e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_data", 64'(out_data), 64'(prev_beat.data));
          check("stall_index", 64'(out_index), 64'(prev_beat.idx));
          check("stall_last", 64'(out_last), 64'(prev_beat.last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0h index %0d, none expected", out_data, out_index);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(out_data), 64'(e.data));
            check("beat_index", 64'(out_index), 64'(e.idx));
            check("beat_last", 64'(out_last), 64'(e.last));
          end
          last_hs_cyc = cyc;
        end
        if (drain_done) begin
          check("done_without_valid", 64'(out_valid), 64'd0);
          check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = beat_t'{data: out_data, idx: out_index, last: out_last};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stalled;
    reset            = 1'b1;
    done_matrix_mult = 1'b0;
    out_ready        = 1'b0;
    y                = '0;
    repeat (3) tick;
    check_zero("reset");
    reset = 1'b0;
    tick;

    // Basic drain: A=I so C equals B = 1..16.
    for (int i = 0; i < 16; i++) begin
      set_elem(i, 32'(i + 1));
      push(i, 32'(i + 1));
    end
    out_ready        = 1'b1;
    done_matrix_mult = 1'b1;
    @(negedge clk);
    check("pre_capture_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("capture_latency_valid", 64'(out_valid), 64'd1);
    check("capture_first_index", 64'(out_index), 64'd0);
    wait_drain("basic");
    done_matrix_mult = 1'b0;
    tick;

    // Backpressure with a 5-cycle stall at index 7, and y overwritten mid-stream.
    for (int i = 0; i < 16; i++) begin
      set_elem(i, 32'h100 + 32'(i * 7));
      push(i, 32'h100 + 32'(i * 7));
    end
    out_ready        = 1'b0;
    done_matrix_mult = 1'b1;
    stalled          = 1'b0;
    for (int k = 0; k < 300 && !drain_done; k++) begin
      tick;
      if (out_valid && out_index == 4'd2) y = '1;
      if (out_valid && out_index == 4'd7 && !stalled) begin
        out_ready = 1'b0;
        repeat (5) tick;
        stalled   = 1'b1;
        out_ready = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    check("bp_stall_hit", 64'(stalled), 64'd1);
    out_ready = 1'b1;
    wait_drain("backpressure");
    done_matrix_mult = 1'b0;
    tick;

    // Overrun: re-raise done at index 3; stream keeps the original data.
    for (int i = 0; i < 16; i++) begin
      set_elem(i, 32'(-(i + 1) * 1000));
      push(i, 32'(-(i + 1) * 1000));
    end
    done_matrix_mult = 1'b1;
    check("overrun_before", 64'(overrun), 64'd0);
    wait_index(4'd3, "overrun");
    done_matrix_mult = 1'b0;
    set_elem(5, 32'h0BAD_0BAD);
    tick;
    done_matrix_mult = 1'b1;
    tick;
    check("overrun_set", 64'(overrun), 64'd1);
    wait_drain("overrun");
    check("overrun_sticky", 64'(overrun), 64'd1);
    done_matrix_mult = 1'b0;
    tick;

    // Reset at index 9; done held high across release recaptures.
    for (int i = 0; i < 16; i++) begin
      set_elem(i, 32'(i * i + 3));
      push(i, 32'(i * i + 3));
    end
    done_matrix_mult = 1'b1;
    wait_index(4'd9, "midreset");
    reset = 1'b1;
    #1;
    check_zero("midreset");
    exp_q.delete();
    for (int i = 0; i < 16; i++) push(i, 32'(i * i + 3));
    tick;
    tick;
    reset = 1'b0;
    wait_drain("post_reset");
    done_matrix_mult = 1'b0;
    tick;

    // Saturation corners.
    y = '0;
    set_elem(0, 32'd40000);
    set_elem(1, 32'hFFFF_63C0);
    set_elem(2, 32'd1234);
`ifdef MAC_DRAIN_SAT16_EN
    push(0, 32'd32767);
    push(1, 32'hFFFF_8000);
`else
    push(0, 32'd40000);
    push(1, 32'hFFFF_63C0);
`endif
    push(2, 32'd1234);
    for (int i = 3; i < 16; i++) push(i, 32'd0);
    done_matrix_mult = 1'b1;
    wait_drain("saturation");
    done_matrix_mult = 1'b0;
    repeat (2) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
